// File: rtl/seq_pkg.sv
// Shared types for the MIPS control sequencer: ALU op codes, opcode/funct values, FSM states, decoded control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7
    } alu_op_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WRITE,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    writes;
        alu_op_t op;
        logic    is_beq;
        logic    is_halt;
        logic    is_illegal;
    } ctrl_t;

endpackage

// File: rtl/mips_control_sequencer_if.sv
// Instruction-memory fetch port plus datapath control/flag signals between sequencer and datapath.
// Latency: n/a (wires only).
// Backpressure: imem_ready stalls the fetch; the datapath side has no backpressure.
interface mips_control_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_data;
    logic            Z;
    logic            RegDst;
    logic            ALUSrc;
    logic            RegWrite;
    logic [3:0]      op;
    logic [25:0]     instruction;

    modport master (
        output imem_req, imem_addr, RegDst, ALUSrc, RegWrite, op, instruction,
        input  imem_ready, imem_data, Z
    );

    modport slave (
        input  imem_req, imem_addr, RegDst, ALUSrc, RegWrite, op, instruction,
        output imem_ready, imem_data, Z
    );
endinterface

// File: rtl/seq_decoder.sv
// Combinational decode of a 32-bit MIPS word into sequencer control fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seq_decoder
    import seq_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl
);

    // Decode opcode/funct; anything unrecognised is flagged illegal with no write.
    always_comb begin
        ctrl = '0;
        if (ir == HALT_WORD) begin
            ctrl.is_halt = 1'b1;
        end else begin
            case (ir[31:26])
                OPC_RTYPE: begin
                    ctrl.reg_dst = 1'b1;
                    ctrl.writes  = 1'b1;
                    case (ir[5:0])
                        FN_ADD:  ctrl.op = ALU_ADD;
                        FN_SUB:  ctrl.op = ALU_SUB;
                        FN_AND:  ctrl.op = ALU_AND;
                        FN_OR:   ctrl.op = ALU_OR;
                        FN_SLT:  ctrl.op = ALU_SLT;
                        default: begin
                            ctrl.reg_dst    = 1'b0;
                            ctrl.writes     = 1'b0;
                            ctrl.is_illegal = 1'b1;
                        end
                    endcase
                end
                OPC_ADDI: begin
                    ctrl.alu_src = 1'b1;
                    ctrl.writes  = 1'b1;
                    ctrl.op      = ALU_ADD;
                end
                OPC_ANDI: begin
                    ctrl.alu_src = 1'b1;
                    ctrl.writes  = 1'b1;
                    ctrl.op      = ALU_AND;
                end
                OPC_ORI: begin
                    ctrl.alu_src = 1'b1;
                    ctrl.writes  = 1'b1;
                    ctrl.op      = ALU_OR;
                end
                OPC_BEQ: begin
                    ctrl.is_beq = 1'b1;
                    ctrl.op     = ALU_SUB;
                end
                default: ctrl.is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mips_control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WRITE sequencer driving datapath controls; SEQ_ILLEGAL_TRAP_EN traps illegal words to HALT.
// Latency: 4 cycles per instruction with a first-cycle imem_ready, +1 per fetch wait cycle.
// Backpressure: FETCH holds imem_req/imem_addr until imem_ready; start is ignored while busy.
module mips_control_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    mips_control_sequencer_if.master bus,
    output logic                     busy,
    output logic                     halted
`ifdef SEQ_ILLEGAL_TRAP_EN
    ,
    output logic                     illegal
`endif
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            taken_q, taken_d;
    logic            illegal_q, illegal_d;
    ctrl_t           ctrl;
    logic [PC_W-1:0] br_off;

    seq_decoder u_decoder (
        .ir   (ir_q),
        .ctrl (ctrl)
    );

    // Branch offset: sign-extended 16-bit immediate, truncated to the pc width.
    always_comb begin
        br_off = PC_W'({{16{ir_q[15]}}, ir_q[15:0]});
    end

    // State, pc, IR and flags; synchronous reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and control outputs; controls are only live from DECODE through WRITE.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ir_d            = ir_q;
        taken_d         = taken_q;
        illegal_d       = illegal_q;
        bus.imem_req    = 1'b0;
        bus.imem_addr   = '0;
        bus.RegDst      = 1'b0;
        bus.ALUSrc      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.op          = 4'd0;
        bus.instruction = ir_q[25:0];
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (state_q == ST_HALT) begin
                    bus.instruction = '0;
                end
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    illegal_d = 1'b0;
                end
            end
            ST_FETCH: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = pc_q;
                if (bus.imem_ready) begin
                    ir_d    = bus.imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE, ST_EXEC, ST_WRITE: begin
                bus.RegDst = ctrl.reg_dst;
                bus.ALUSrc = ctrl.alu_src;
                bus.op     = ctrl.op;
                if (state_q == ST_DECODE) begin
                    if (ctrl.is_halt) begin
                        state_d = ST_HALT;
`ifdef SEQ_ILLEGAL_TRAP_EN
                    end else if (ctrl.is_illegal) begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
`endif
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else if (state_q == ST_EXEC) begin
                    taken_d = ctrl.is_beq & bus.Z;
                    state_d = ST_WRITE;
                end else begin
                    // Illegal words reaching WRITE behave as NOPs.
                    bus.RegWrite = ctrl.writes & ~ctrl.is_illegal;
                    pc_d         = taken_q ? (pc_q + PC_W'(1) + br_off) : (pc_q + PC_W'(1));
                    taken_d      = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted = (state_q == ST_HALT);
`ifdef SEQ_ILLEGAL_TRAP_EN
        illegal = illegal_q;
`endif
    end

endmodule

// File: tb/tb_mips_control_sequencer.sv
// Directed bench for mips_control_sequencer: scoreboarded expected controls per fetched word, SEQ_ILLEGAL_TRAP_EN aware.
// Latency: checks the 4-cycle FETCH/DECODE/EXEC/WRITE sequence and fetch wait-state stretching.
// Backpressure: exercises delayed imem_ready and start pulses while busy.
module tb_mips_control_sequencer;

    typedef struct {
        logic [3:0] op;
        logic       rd;
        logic       as;
        logic       wr;
        logic       halt;
        logic       ctrl_dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic halted;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    mips_control_sequencer_if #(.PC_W(8)) bus ();

    mips_control_sequencer #(.PC_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (bus),
        .busy   (busy),
`ifdef SEQ_ILLEGAL_TRAP_EN
        .halted (halted),
        .illegal(illegal)
`else
        .halted (halted)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic rd, input logic as,
                                input logic wr, input logic halt, input logic dc);
        exp_t e;
        e.op = op; e.rd = rd; e.as = as; e.wr = wr; e.halt = halt; e.ctrl_dc = dc;
        return e;
    endfunction

    task automatic wait_req(input string tag);
        for (int i = 0; i < 30 && bus.imem_req !== 1'b1; i++) tick();
        check({tag, "_req_seen"}, {31'd0, bus.imem_req}, 32'd1);
    endtask

    task automatic check_ctrl(input string tag, input exp_t x, input logic wr);
        if (!x.ctrl_dc) begin
            check({tag, "_op"}, {28'd0, bus.op}, {28'd0, x.op});
            check({tag, "_RegDst"}, {31'd0, bus.RegDst}, {31'd0, x.rd});
            check({tag, "_ALUSrc"}, {31'd0, bus.ALUSrc}, {31'd0, x.as});
        end
        check({tag, "_RegWrite"}, {31'd0, bus.RegWrite}, {31'd0, wr});
    endtask

    // One instruction: fetch at addr with dly wait cycles, then follow it through to the next fetch.
    task automatic run_instr(input string tag, input logic [7:0] addr, input logic [31:0] word,
                             input int dly, input logic z, input exp_t e, input logic poke_start);
        exp_t x;
        wait_req(tag);
        check({tag, "_addr"}, {24'd0, bus.imem_addr}, {24'd0, addr});
        for (int i = 0; i < dly; i++) begin
            start = poke_start && (i == 0);
            tick();
            start = 1'b0;
            check({tag, "_req_hold"}, {31'd0, bus.imem_req}, 32'd1);
            check({tag, "_addr_hold"}, {24'd0, bus.imem_addr}, {24'd0, addr});
        end
        bus.imem_ready = 1'b1;
        bus.imem_data  = word;
        sb.push_back(e);
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_data  = 32'h0;
        x = sb.pop_front();
        check({tag, "_dec_RegWrite"}, {31'd0, bus.RegWrite}, 32'd0);
        if (x.halt) begin
            tick();
            check({tag, "_halted"}, {31'd0, halted}, 32'd1);
            check({tag, "_busy"}, {31'd0, busy}, 32'd0);
            check({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
            check({tag, "_halt_RegWrite"}, {31'd0, bus.RegWrite}, 32'd0);
            return;
        end
        check_ctrl({tag, "_dec"}, x, 1'b0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        bus.Z = z;
        tick();
        check_ctrl({tag, "_exec"}, x, 1'b0);
        tick();
        bus.Z = 1'b0;
        check_ctrl({tag, "_write"}, x, x.wr);
        tick();
        check({tag, "_post_RegWrite"}, {31'd0, bus.RegWrite}, 32'd0);
    endtask

    initial begin
        exp_t e_add, e_addi, e_ori, e_andi, e_sub, e_beq, e_slt, e_or, e_halt, e_ill;
        e_add  = mk(4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        e_addi = mk(4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        e_ori  = mk(4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        e_andi = mk(4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        e_sub  = mk(4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        e_beq  = mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_slt  = mk(4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        e_or   = mk(4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        e_halt = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef SEQ_ILLEGAL_TRAP_EN
        e_ill  = e_halt;
`else
        e_ill  = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        rst = 1'b1; start = 1'b0;
        bus.imem_ready = 1'b0; bus.imem_data = 32'h0; bus.Z = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("rst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        check("rst_op", {28'd0, bus.op}, 32'd0);
        check("rst_instruction", {6'd0, bus.instruction}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
`ifdef SEQ_ILLEGAL_TRAP_EN
        check("rst_illegal", {31'd0, illegal}, 32'd0);
`endif

        start = 1'b1; tick(); start = 1'b0;
        run_instr("add",  8'd0, 32'h012A_4020, 0, 1'b0, e_add,  1'b0);
        run_instr("addi", 8'd1, 32'h2108_0005, 3, 1'b0, e_addi, 1'b1);
        run_instr("ori",  8'd2, 32'h3508_0001, 0, 1'b0, e_ori,  1'b0);
        run_instr("andi", 8'd3, 32'h3108_00FF, 1, 1'b0, e_andi, 1'b0);
        run_instr("sub",  8'd4, 32'h012A_4022, 0, 1'b0, e_sub,  1'b0);
        run_instr("beqt", 8'd5, 32'h1109_FFFD, 0, 1'b1, e_beq,  1'b0);
        run_instr("slt",  8'd3, 32'h012A_402A, 0, 1'b0, e_slt,  1'b0);
        run_instr("or",   8'd4, 32'h012A_4025, 0, 1'b0, e_or,   1'b0);
        run_instr("beqn", 8'd5, 32'h1109_FFFD, 0, 1'b0, e_beq,  1'b0);
        run_instr("ill",  8'd6, 32'hFC00_0000, 0, 1'b0, e_ill,  1'b0);
`ifdef SEQ_ILLEGAL_TRAP_EN
        check("ill_flag", {31'd0, illegal}, 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        check("ill_clear", {31'd0, illegal}, 32'd0);
        check("ill_restart_addr", {24'd0, bus.imem_addr}, 32'd0);
`else
        wait_req("ill_next");
        check("ill_next_addr", {24'd0, bus.imem_addr}, 32'd7);
`endif

        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        run_instr("h_add0", 8'd0, 32'h012A_4020, 0, 1'b0, e_add,  1'b0);
        run_instr("h_add1", 8'd1, 32'h012A_4020, 0, 1'b0, e_add,  1'b0);
        run_instr("halt",   8'd2, 32'hFFFF_FFFF, 0, 1'b0, e_halt, 1'b0);
        bus.imem_ready = 1'b1; tick(); tick(); bus.imem_ready = 1'b0;
        check("halt_stays", {31'd0, halted}, 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_halted", {31'd0, halted}, 32'd0);
        check("restart_req", {31'd0, bus.imem_req}, 32'd1);
        check("restart_addr", {24'd0, bus.imem_addr}, 32'd0);

        bus.imem_ready = 1'b1; bus.imem_data = 32'h012A_4020;
        tick();
        bus.imem_ready = 1'b0;
        tick(); tick();
        check("rw_RegWrite", {31'd0, bus.RegWrite}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rw_rst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        check("rw_rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rw_rst_busy", {31'd0, busy}, 32'd0);
        check("rw_rst_op", {28'd0, bus.op}, 32'd0);
        check("rw_rst_RegDst", {31'd0, bus.RegDst}, 32'd0);
        check("rw_rst_instruction", {6'd0, bus.instruction}, 32'd0);
        tick();
        check("rw_idle_req", {31'd0, bus.imem_req}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("rw_restart_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("rw_restart_req", {31'd0, bus.imem_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
